// File: rtl/countdown_timer.sv
// Countdown timer: loads a two-digit BCD preset, decrements it once per
// second from a prescaled system clock, supports pause/resume and cancel,
// and raises a one-cycle timeout pulse when the count reaches 00.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   reset     asynchronous active-high reset
//   preset    BCD load value {tens, ones}, sampled on an accepted start
//   start     pulse: load preset and begin counting (rejected if not BCD)
//   pause     pulse: toggle RUN <-> PAUSED, ignored elsewhere
//   cancel    pulse: abort to IDLE, highest priority
//   seconds   {active, tens, ones} for the display driver
//   timeout   one-cycle pulse on expiry
//   busy      high while RUN or PAUSED
//   load_err  one-cycle pulse when a start carries an invalid preset
//
// Input priority per cycle: cancel > start > pause > internal tick.
// All outputs come straight from flops.

module countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] preset,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  output logic [8:0] seconds,
  output logic       timeout,
  output logic       busy,
  output logic       load_err
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPaused,
    StExpired
  } state_e;

  localparam logic [CNT_W-1:0] PrescLast = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] PrescOne  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             active_q, active_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             load_err_q, load_err_d;

  // Preset decode
  logic preset_valid;
  logic preset_zero;

  assign preset_valid = (preset[7:4] <= 4'd9) && (preset[3:0] <= 4'd9);
  assign preset_zero  = (preset == 8'h00);

  // One-second tick: only meaningful while running
  logic tick;

  assign tick = (state_q == StRun) && (presc_q == PrescLast);

  // BCD decrement of the current count. Never applied at 00 because the
  // 01 -> 00 step is handled as expiry instead.
  logic [3:0] dec_tens;
  logic [3:0] dec_ones;
  logic       last_sec;

  always_comb begin
    dec_tens = tens_q;
    dec_ones = ones_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
    end
  end

  assign last_sec = (tens_q == 4'd0) && (ones_q == 4'd1);

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    active_d   = active_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    load_err_d = 1'b0;

    if (cancel) begin
      state_d  = StIdle;
      presc_d  = '0;
      tens_d   = 4'd0;
      ones_d   = 4'd0;
      active_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      if (!preset_valid) begin
        // Rejected start consumes the cycle: nothing else advances.
        load_err_d = 1'b1;
      end else if (preset_zero) begin
        state_d   = StExpired;
        presc_d   = '0;
        tens_d    = 4'd0;
        ones_d    = 4'd0;
        active_d  = 1'b1;
        busy_d    = 1'b0;
        timeout_d = 1'b1;
      end else begin
        state_d  = StRun;
        presc_d  = '0;
        tens_d   = preset[7:4];
        ones_d   = preset[3:0];
        active_d = 1'b1;
        busy_d   = 1'b1;
      end
    end else if (pause) begin
      // Toggle only; the prescaler keeps its value across the pause.
      case (state_q)
        StRun:    state_d = StPaused;
        StPaused: state_d = StRun;
        default:  state_d = state_q;
      endcase
    end else if (state_q == StRun) begin
      if (tick) begin
        presc_d = '0;
        if (last_sec) begin
          state_d   = StExpired;
          tens_d    = 4'd0;
          ones_d    = 4'd0;
          active_d  = 1'b1;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          tens_d = dec_tens;
          ones_d = dec_ones;
        end
      end else begin
        presc_d = presc_q + PrescOne;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      active_q   <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      active_q   <= active_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      load_err_q <= load_err_d;
    end
  end

  assign seconds  = {active_q, tens_q, ones_q};
  assign timeout  = timeout_q;
  assign busy     = busy_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with TICKS_PER_SEC = 4.
module tb_countdown_timer;

  localparam int unsigned Ticks = 4;

  logic       clk;
  logic       reset;
  logic [7:0] preset;
  logic       start;
  logic       pause;
  logic       cancel;
  logic [8:0] seconds;
  logic       timeout;
  logic       busy;
  logic       load_err;

  int checks;
  int errors;

  countdown_timer #(
    .TICKS_PER_SEC(Ticks),
    .CNT_W        (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .preset  (preset),
    .start   (start),
    .pause   (pause),
    .cancel  (cancel),
    .seconds (seconds),
    .timeout (timeout),
    .busy    (busy),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [8:0] sec, input logic to,
                           input logic bz, input logic le);
    check({name, " seconds"}, seconds, sec);
    check({name, " timeout"}, {8'h00, timeout}, {8'h00, to});
    check({name, " busy"}, {8'h00, busy}, {8'h00, bz});
    check({name, " load_err"}, {8'h00, load_err}, {8'h00, le});
  endtask

  // Drive one cycle of inputs, clock, sample 1 time unit after the edge.
  task automatic step(input logic s, input logic p, input logic c, input logic [7:0] pr);
    start  = s;
    pause  = p;
    cancel = c;
    preset = pr;
    @(posedge clk);
    #1;
    start  = 1'b0;
    pause  = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, preset);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Table vectors
  typedef struct {
    logic       s;
    logic       p;
    logic       c;
    logic [7:0] pr;
    logic [8:0] sec;
    logic       to;
    logic       bz;
    logic       le;
  } vec_t;

  vec_t vecs[21];

  // Reference model: integer count and phase, per-rule update
  int m_mode;  // 0 idle, 1 run, 2 paused, 3 expired
  int m_n;
  int m_phase;
  bit m_to;
  bit m_le;

  function automatic logic [8:0] m_seconds();
    logic [8:0] r;
    case (m_mode)
      1, 2:    r = {1'b1, 4'(m_n / 10), 4'(m_n % 10)};
      3:       r = 9'h100;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  task automatic model_step(input bit s, input bit p, input bit c, input logic [7:0] pr);
    int hi;
    int lo;
    hi   = int'(pr[7:4]);
    lo   = int'(pr[3:0]);
    m_to = 0;
    m_le = 0;
    if (c) begin
      m_mode  = 0;
      m_n     = 0;
      m_phase = 0;
    end else if (s) begin
      if (hi > 9 || lo > 9) begin
        m_le = 1;
      end else if (hi * 10 + lo == 0) begin
        m_mode  = 3;
        m_n     = 0;
        m_phase = 0;
        m_to    = 1;
      end else begin
        m_mode  = 1;
        m_n     = hi * 10 + lo;
        m_phase = 0;
      end
    end else if (p) begin
      if (m_mode == 1) m_mode = 2;
      else if (m_mode == 2) m_mode = 1;
    end else if (m_mode == 1) begin
      m_phase++;
      if (m_phase == Ticks) begin
        m_phase = 0;
        m_n--;
        if (m_n == 0) begin
          m_mode = 3;
          m_to   = 1;
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    preset = 8'h00;
    start  = 1'b0;
    pause  = 1'b0;
    cancel = 1'b0;

    do_reset();
    check_all("reset", 9'h000, 1'b0, 1'b0, 1'b0);

    // Load 12 and count through a BCD borrow
    step(1'b1, 1'b0, 1'b0, 8'h12);
    check_all("load12", 9'h112, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      idle();
      if (i == 3) check("12 hold", seconds, 9'h112);
      if (i == 4) check("12 to 11", seconds, 9'h111);
      if (i == 8) check("11 to 10", seconds, 9'h110);
      if (i == 12) check("10 to 09", seconds, 9'h109);
    end

    // Expire from 02 and hold
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h02);
    check_all("load02", 9'h102, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      idle();
      if (i == 3) check("02 hold", seconds, 9'h102);
      if (i == 4) check_all("02 to 01", 9'h101, 1'b0, 1'b1, 1'b0);
      if (i == 7) check("01 hold", seconds, 9'h101);
      if (i == 8) check_all("expire", 9'h100, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) step(1'b0, 1'b1, 1'b0, 8'h00);
      else idle();
      check_all($sformatf("expired hold %0d", i), 9'h100, 1'b0, 1'b0, 1'b0);
    end

    // Pause preserves the prescaler phase
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h05);
    check("load05", seconds, 9'h105);
    for (int i = 1; i <= 6; i++) idle();
    check("05 to 04", seconds, 9'h104);
    step(1'b0, 1'b1, 1'b0, 8'h05);
    check_all("paused", 9'h104, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      idle();
      check($sformatf("paused hold %0d", i), seconds, 9'h104);
    end
    step(1'b0, 1'b1, 1'b0, 8'h05);
    check("resumed", seconds, 9'h104);
    idle();
    check("resume +1", seconds, 9'h104);
    idle();
    check("resume +2", seconds, 9'h103);

    // Invalid preset
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h1A);
    check_all("bad preset", 9'h000, 1'b0, 1'b0, 1'b1);
    idle();
    check_all("bad preset after", 9'h000, 1'b0, 1'b0, 1'b0);

    // Zero preset expires immediately
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check_all("load00", 9'h100, 1'b1, 1'b0, 1'b0);

    // Cancel beats start
    step(1'b1, 1'b0, 1'b1, 8'h30);
    check_all("cancel+start", 9'h000, 1'b0, 1'b0, 1'b0);
    idle();
    check_all("cancel idle", 9'h000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-count
    step(1'b1, 1'b0, 1'b0, 8'h30);
    for (int i = 1; i <= 12; i++) idle();
    check("at 27", seconds, 9'h127);
    #2;
    reset = 1'b1;
    #1;
    check_all("async reset", 9'h000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle();
      check_all($sformatf("post reset %0d", i), 9'h000, 1'b0, 1'b0, 1'b0);
    end

    // Table-driven sequence from a fresh reset
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h12, 9'h112, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h12, 9'h112, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h12, 9'h112, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h12, 9'h112, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h12, 9'h111, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h12, 9'h111, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h12, 9'h111, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h12, 9'h111, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h1A, 9'h111, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h1A, 9'h111, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h05, 9'h000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 9'h100, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 9'h100, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h01, 9'h101, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h01, 9'h101, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h01, 9'h101, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h01, 9'h101, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 8'h01, 9'h100, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 8'h01, 9'h100, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 8'h01, 9'h000, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 8'h01, 9'h000, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 21; i++) begin
      step(vecs[i].s, vecs[i].p, vecs[i].c, vecs[i].pr);
      check_all($sformatf("vec%0d", i), vecs[i].sec, vecs[i].to, vecs[i].bz, vecs[i].le);
    end

    // Randomized run against the reference model
    do_reset();
    m_mode  = 0;
    m_n     = 0;
    m_phase = 0;
    for (int i = 0; i < 3000; i++) begin
      bit         s;
      bit         p;
      bit         c;
      logic [7:0] pr;
      s = ($urandom_range(0, 39) == 0);
      p = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) pr = 8'($urandom_range(0, 255));
      else pr = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
      model_step(s, p, c, pr);
      step(s, p, c, pr);
      check_all($sformatf("rand%0d", i), m_seconds(), m_to, (m_mode == 1 || m_mode == 2),
                m_le);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
